// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Used by mem_ctrl and mem_ctrl_arb.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IC_READ,
        MEM_READ,
        MEM_WRITE
    } state_e;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    // addr[17:16] value that marks the memory-mapped I/O region
    localparam logic [1:0] IO_REGION = 2'b11;

    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            LEN_B, LEN_H, LEN_W: return len;
            default:             return LEN_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Request arbiter: grants only in an accepting IDLE cycle, MEM over IC.
// i_io_full blocks I/O-region stores (tied low unless MEM_CTRL_IO_GUARD_EN).
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic       i_idle,
    input  logic       i_ic_e,
    input  logic       i_mem_e,
    input  logic       i_mem_wr,
    input  logic [1:0] i_mem_region,
    input  logic       i_io_full,
    output logic       o_grant_mem,
    output logic       o_grant_ic
);

    logic w_io_blocked;
    logic w_mem_req;

    always_comb begin
        w_io_blocked = i_mem_wr && (i_mem_region == IO_REGION) && i_io_full;
        w_mem_req    = i_mem_e && !w_io_blocked;
        o_grant_mem  = i_idle && w_mem_req;
        // a blocked store does not starve the instruction port
        o_grant_ic   = i_idle && i_ic_e && !w_mem_req;
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller serving an ICache port and a load/store port.
// Optional MEM_CTRL_IO_GUARD_EN adds io_buffer_full_in to hold off I/O stores.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        IC_E_in,
    input  logic [31:0] IC_addr_in,
    output logic        IC_instE_out,
    output logic [31:0] IC_inst_out,
    output logic        IC_busy_out,
    input  logic        MEM_E_in,
    input  logic        MEM_wr_in,
    input  logic [31:0] MEM_addr_in,
    input  logic [2:0]  MEM_len_in,
    input  logic [31:0] MEM_data_in,
    output logic        MEM_dataE_out,
    output logic [31:0] MEM_data_out,
    output logic        MEM_busy_out,
    input  logic [7:0]  ram_din_in,
    output logic [7:0]  ram_dout_out,
    output logic [31:0] ram_a_out,
    output logic        ram_wr_out
`ifdef MEM_CTRL_IO_GUARD_EN
    ,
    input  logic        io_buffer_full_in
`endif
);

    state_e      r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_len;
    logic [31:0] r_data;
    logic [2:0]  r_pos;
    logic [2:0]  r_cnt;
    logic        r_pend;
    logic [31:0] r_buf;
    logic [31:0] r_ram_a;
    logic [7:0]  r_ram_dout;
    logic        r_ram_wr;
    logic        r_ic_done;
    logic [31:0] r_ic_inst;
    logic        r_ic_busy;
    logic        r_mem_done;
    logic [31:0] r_mem_data;
    logic        r_mem_busy;

    logic        w_idle;
    logic        w_io_full;
    logic        w_grant_mem;
    logic        w_grant_ic;
    logic [2:0]  w_next_pos;
    logic [2:0]  w_cnt_next;
    logic [7:0]  w_next_byte;
    logic [31:0] w_buf_cap;

`ifdef MEM_CTRL_IO_GUARD_EN
    assign w_io_full = io_buffer_full_in;
`else
    assign w_io_full = 1'b0;
`endif

    // the done cycle is already IDLE but must not accept a new request
    assign w_idle = (r_state == IDLE) && !r_ic_done && !r_mem_done && rdy_in;

    mem_ctrl_arb u_arb (
        .i_idle       (w_idle),
        .i_ic_e       (IC_E_in),
        .i_mem_e      (MEM_E_in),
        .i_mem_wr     (MEM_wr_in),
        .i_mem_region (MEM_addr_in[17:16]),
        .i_io_full    (w_io_full),
        .o_grant_mem  (w_grant_mem),
        .o_grant_ic   (w_grant_ic)
    );

    always_comb begin
        w_next_pos  = r_pos + 3'd1;
        w_cnt_next  = r_cnt + 3'd1;
        w_next_byte = r_data[{w_next_pos[1:0], 3'b000} +: 8];
        w_buf_cap   = r_buf;
        w_buf_cap[{r_cnt[1:0], 3'b000} +: 8] = ram_din_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_data     <= '0;
            r_pos      <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_buf      <= '0;
            r_ram_a    <= '0;
            r_ram_dout <= '0;
            r_ram_wr   <= 1'b0;
            r_ic_done  <= 1'b0;
            r_ic_inst  <= '0;
            r_ic_busy  <= 1'b0;
            r_mem_done <= 1'b0;
            r_mem_data <= '0;
            r_mem_busy <= 1'b0;
        end else begin
            r_ic_done  <= 1'b0;
            r_mem_done <= 1'b0;
            if (r_ic_done)  r_ic_busy  <= 1'b0;
            if (r_mem_done) r_mem_busy <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_pos  <= '0;
                    r_cnt  <= '0;
                    r_pend <= 1'b0;
                    r_buf  <= '0;
                    if (w_grant_mem) begin
                        r_addr     <= MEM_addr_in;
                        r_len      <= norm_len(MEM_len_in);
                        r_data     <= MEM_data_in;
                        r_ram_a    <= MEM_addr_in;
                        r_mem_busy <= 1'b1;
                        if (MEM_wr_in) begin
                            r_state    <= MEM_WRITE;
                            r_ram_wr   <= 1'b1;
                            r_ram_dout <= MEM_data_in[7:0];
                        end else begin
                            r_state <= MEM_READ;
                        end
                    end else if (w_grant_ic) begin
                        r_addr    <= IC_addr_in;
                        r_len     <= LEN_W;
                        r_ram_a   <= IC_addr_in;
                        r_ic_busy <= 1'b1;
                        r_state   <= IC_READ;
                    end
                end
                IC_READ, MEM_READ: begin
                    if (rdy_in) begin
                        if (r_pend) begin
                            r_buf <= w_buf_cap;
                            r_cnt <= w_cnt_next;
                        end
                        if (r_pend && (w_cnt_next == r_len)) begin
                            r_state <= IDLE;
                            r_pend  <= 1'b0;
                            r_ram_a <= '0;
                            if (r_state == IC_READ) begin
                                r_ic_done <= 1'b1;
                                r_ic_inst <= w_buf_cap;
                            end else begin
                                r_mem_done <= 1'b1;
                                r_mem_data <= w_buf_cap;
                            end
                        end else if (r_pos < r_len) begin
                            r_pend  <= 1'b1;
                            r_pos   <= w_next_pos;
                            r_ram_a <= r_addr + {29'd0, w_next_pos};
                        end else begin
                            r_pend <= 1'b0;
                        end
                    end else if (r_pend) begin
                        // the outstanding byte is lost while frozen: rewind to it
                        r_pend  <= 1'b0;
                        r_pos   <= r_cnt;
                        r_ram_a <= r_addr + {29'd0, r_cnt};
                    end
                end
                MEM_WRITE: begin
                    if (rdy_in) begin
                        if (w_next_pos == r_len) begin
                            r_state    <= IDLE;
                            r_ram_wr   <= 1'b0;
                            r_ram_a    <= '0;
                            r_ram_dout <= '0;
                            r_mem_done <= 1'b1;
                        end else begin
                            r_pos      <= w_next_pos;
                            r_ram_a    <= r_addr + {29'd0, w_next_pos};
                            r_ram_dout <= w_next_byte;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign IC_instE_out  = r_ic_done;
    assign IC_inst_out   = r_ic_inst;
    assign IC_busy_out   = r_ic_busy;
    assign MEM_dataE_out = r_mem_done;
    assign MEM_data_out  = r_mem_data;
    assign MEM_busy_out  = r_mem_busy;
    assign ram_dout_out  = r_ram_dout;
    assign ram_a_out     = r_ram_a;
    assign ram_wr_out    = r_ram_wr && rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomized bench for mem_ctrl with a byte-array RAM and shadow model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        IC_E_in = 1'b0;
    logic [31:0] IC_addr_in = '0;
    logic        IC_instE_out;
    logic [31:0] IC_inst_out;
    logic        IC_busy_out;
    logic        MEM_E_in = 1'b0;
    logic        MEM_wr_in = 1'b0;
    logic [31:0] MEM_addr_in = '0;
    logic [2:0]  MEM_len_in = '0;
    logic [31:0] MEM_data_in = '0;
    logic        MEM_dataE_out;
    logic [31:0] MEM_data_out;
    logic        MEM_busy_out;
    logic [7:0]  ram_din_in;
    logic [7:0]  ram_dout_out;
    logic [31:0] ram_a_out;
    logic        ram_wr_out;
`ifdef MEM_CTRL_IO_GUARD_EN
    logic        io_buffer_full_in = 1'b0;
`endif

    logic [7:0] ram     [0:4095];
    logic [7:0] ref_mem [0:4095];
    bit         preload = 1'b1;
    int         errors = 0;
    int         checks = 0;

    always #5 clk_in = ~clk_in;

    mem_ctrl dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .IC_E_in       (IC_E_in),
        .IC_addr_in    (IC_addr_in),
        .IC_instE_out  (IC_instE_out),
        .IC_inst_out   (IC_inst_out),
        .IC_busy_out   (IC_busy_out),
        .MEM_E_in      (MEM_E_in),
        .MEM_wr_in     (MEM_wr_in),
        .MEM_addr_in   (MEM_addr_in),
        .MEM_len_in    (MEM_len_in),
        .MEM_data_in   (MEM_data_in),
        .MEM_dataE_out (MEM_dataE_out),
        .MEM_data_out  (MEM_data_out),
        .MEM_busy_out  (MEM_busy_out),
        .ram_din_in    (ram_din_in),
        .ram_dout_out  (ram_dout_out),
        .ram_a_out     (ram_a_out),
        .ram_wr_out    (ram_wr_out)
`ifdef MEM_CTRL_IO_GUARD_EN
        ,
        .io_buffer_full_in (io_buffer_full_in)
`endif
    );

    // RAM: one-cycle read latency, write on ram_wr_out
    always @(posedge clk_in) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'((i * 37 + 11) & 255);
        end else if (ram_wr_out) begin
            ram[ram_a_out[11:0]] <= ram_dout_out;
        end
        ram_din_in <= ram[ram_a_out[11:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int legal_len(input logic [2:0] len);
        return (len == 3'd1 || len == 3'd2 || len == 3'd4) ? int'(len) : 4;
    endfunction

    function automatic logic [11:0] ix(input logic [31:0] addr, input int k);
        return addr[11:0] + 12'(k);
    endfunction

    // One transaction from an idle controller; extra < 0 skips the latency check.
    task automatic txn(input bit is_ic, input bit wr, input logic [31:0] addr,
                       input logic [2:0] len, input logic [31:0] data,
                       input int stall_at, input int stall_len, input int extra);
        int          n;
        int          lat;
        int          bad_wr;
        int          base;
        logic [31:0] exp_word;
        n        = is_ic ? 4 : legal_len(len);
        base     = wr ? n + 1 : n + 2;
        exp_word = '0;
        for (int k = 0; k < n; k++) exp_word = exp_word | (32'(ref_mem[ix(addr, k)]) << (8 * k));
        @(posedge clk_in); #1;
        if (is_ic) begin
            IC_E_in = 1'b1; IC_addr_in = addr;
        end else begin
            MEM_E_in = 1'b1; MEM_wr_in = wr; MEM_addr_in = addr;
            MEM_len_in = len; MEM_data_in = data;
        end
        lat    = -1;
        bad_wr = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk_in); #1;
            if (k == 1) begin
                IC_E_in = 1'b0; MEM_E_in = 1'b0;
            end
            rdy_in = !(stall_at != 0 && k >= stall_at && k < stall_at + stall_len);
            @(negedge clk_in);
            if (!rdy_in && ram_wr_out) bad_wr++;
            if ((is_ic && MEM_dataE_out) || (!is_ic && IC_instE_out)) bad_wr++;
            if ((is_ic && IC_instE_out) || (!is_ic && MEM_dataE_out)) begin
                lat = k;
                break;
            end
        end
        rdy_in = 1'b1;
        if (extra >= 0) chk($sformatf("latency@%h", addr), 32'(lat), 32'(base + extra));
        else            chk($sformatf("done_seen@%h", addr), 32'(lat > 0), 32'd1);
        chk($sformatf("stray_strobe@%h", addr), 32'(bad_wr), 32'd0);
        if (wr) begin
            for (int k = 0; k < n; k++) ref_mem[ix(addr, k)] = data[8 * k +: 8];
            for (int k = 0; k < n; k++)
                chk($sformatf("ram[%h]", ix(addr, k)), 32'(ram[ix(addr, k)]),
                    32'(ref_mem[ix(addr, k)]));
        end else if (is_ic) begin
            chk($sformatf("ic_inst@%h", addr), IC_inst_out, exp_word);
        end else begin
            chk($sformatf("mem_data@%h", addr), MEM_data_out, exp_word);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'((i * 37 + 11) & 255);
        @(posedge clk_in); #1;
        preload = 1'b0;
        @(negedge clk_in);
        chk("rst_ram_a", ram_a_out, 32'd0);
        chk("rst_ram_wr", 32'(ram_wr_out), 32'd0);
        chk("rst_ic_busy", 32'(IC_busy_out), 32'd0);
        chk("rst_mem_busy", 32'(MEM_busy_out), 32'd0);
        chk("rst_ic_inst", IC_inst_out, 32'd0);
        chk("rst_mem_data", MEM_data_out, 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // program the words the directed reads expect
        txn(1'b0, 1'b1, 32'h104, 3'd4, 32'h0000_0513, 0, 0, 0);
        txn(1'b0, 1'b1, 32'h200, 3'd2, 32'h0000_ABCD, 0, 0, 0);

        // IC fetch: busy A+1..A+6, done A+6
        @(posedge clk_in); #1;
        IC_E_in = 1'b1; IC_addr_in = 32'h104;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk_in); #1;
            if (k == 1) IC_E_in = 1'b0;
            @(negedge clk_in);
            chk($sformatf("ic_busy@A+%0d", k), 32'(IC_busy_out), 32'(k <= 6));
            chk($sformatf("ic_done@A+%0d", k), 32'(IC_instE_out), 32'(k == 6));
            if (k == 1) chk("ic_first_addr", ram_a_out, 32'h104);
            if (k == 6) chk("ic_inst_513", IC_inst_out, 32'h0000_0513);
        end

        // simultaneous IC and MEM: MEM first, IC accepted at A+5
        @(posedge clk_in); #1;
        IC_E_in = 1'b1; IC_addr_in = 32'h104;
        MEM_E_in = 1'b1; MEM_wr_in = 1'b0; MEM_addr_in = 32'h200; MEM_len_in = 3'd2;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk_in); #1;
            if (k == 1) MEM_E_in = 1'b0;
            if (k == 6) IC_E_in = 1'b0;
            @(negedge clk_in);
            chk($sformatf("arb_mem_done@A+%0d", k), 32'(MEM_dataE_out), 32'(k == 4));
            if (k == 1) chk("arb_ic_waits", 32'(IC_busy_out), 32'd0);
            if (k == 4) chk("arb_mem_data", MEM_data_out, 32'h0000_ABCD);
            if (k == 5) chk("arb_ic_not_yet", 32'(IC_busy_out), 32'd0);
            if (k == 6) chk("arb_ic_accepted", 32'(IC_busy_out), 32'd1);
            if (k == 11) chk("arb_ic_done", 32'(IC_instE_out), 32'd1);
        end

        // word store: strobes A+1..A+4, done A+5
        @(posedge clk_in); #1;
        MEM_E_in = 1'b1; MEM_wr_in = 1'b1; MEM_addr_in = 32'h300;
        MEM_len_in = 3'd4; MEM_data_in = 32'hDEAD_BEEF;
        for (int k = 1; k <= 6; k++) begin
            logic [31:0] w;
            @(posedge clk_in); #1;
            if (k == 1) MEM_E_in = 1'b0;
            @(negedge clk_in);
            w = 32'hDEAD_BEEF;
            chk($sformatf("st_wr@A+%0d", k), 32'(ram_wr_out), 32'(k <= 4));
            chk($sformatf("st_done@A+%0d", k), 32'(MEM_dataE_out), 32'(k == 5));
            if (k <= 4) begin
                chk($sformatf("st_addr@A+%0d", k), ram_a_out, 32'h300 + 32'(k - 1));
                chk($sformatf("st_byte@A+%0d", k), 32'(ram_dout_out), 32'(w[8 * (k - 1) +: 8]));
            end
        end
        for (int k = 0; k < 4; k++) ref_mem[ix(32'h300, k)] = 8'(32'hDEAD_BEEF >> (8 * k));

        // rdy_in stalls: exact 3-cycle delay when frozen before the first capture
        txn(1'b1, 1'b0, 32'(($urandom_range(0, 900)) * 4), 3'd4, 32'd0, 1, 3, 3);
        txn(1'b0, 1'b1, 32'($urandom_range(0, 3000)), 3'd4, $urandom, 2, 3, 3);
        txn(1'b0, 1'b0, 32'($urandom_range(0, 3000)), 3'd4, 32'd0, 3, 3, -1);

        // asynchronous reset during byte 2 of a store
        @(posedge clk_in); #1;
        MEM_E_in = 1'b1; MEM_wr_in = 1'b1; MEM_addr_in = 32'h340;
        MEM_len_in = 3'd4; MEM_data_in = 32'h1122_3344;
        @(posedge clk_in); #1;
        MEM_E_in = 1'b0;
        @(posedge clk_in); #3;
        rst_in = 1'b1;
        #1;
        chk("arst_ram_wr", 32'(ram_wr_out), 32'd0);
        chk("arst_ram_a", ram_a_out, 32'd0);
        chk("arst_ram_dout", 32'(ram_dout_out), 32'd0);
        chk("arst_mem_busy", 32'(MEM_busy_out), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            chk($sformatf("arst_no_done%0d", k), 32'(MEM_dataE_out), 32'd0);
        end
        ref_mem[12'h340] = 8'h44;
        chk("arst_byte0", 32'(ram[12'h340]), 32'(ref_mem[12'h340]));
        chk("arst_byte1", 32'(ram[12'h341]), 32'(ref_mem[12'h341]));
        txn(1'b0, 1'b0, 32'h340, 3'd4, 32'd0, 0, 0, 0);

`ifdef MEM_CTRL_IO_GUARD_EN
        // guarded I/O store yields to IC, then goes once the buffer drains
        io_buffer_full_in = 1'b1;
        @(posedge clk_in); #1;
        IC_E_in = 1'b1; IC_addr_in = 32'h104;
        MEM_E_in = 1'b1; MEM_wr_in = 1'b1; MEM_addr_in = 32'h0003_0000;
        MEM_len_in = 3'd4; MEM_data_in = 32'hCAFE_F00D;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk_in); #1;
            if (k == 1) IC_E_in = 1'b0;
            if (k == 8) io_buffer_full_in = 1'b0;
            if (k == 9) MEM_E_in = 1'b0;
            @(negedge clk_in);
            if (k == 1) chk("io_ic_served", 32'(IC_busy_out), 32'd1);
            if (k == 1) chk("io_store_held", 32'(MEM_busy_out), 32'd0);
            if (k == 6) chk("io_ic_inst", IC_inst_out, 32'h0000_0513);
            if (k == 7) chk("io_still_held", 32'(MEM_busy_out), 32'd0);
            if (k == 9) chk("io_store_go", ram_a_out, 32'h0003_0000);
            chk($sformatf("io_done@A+%0d", k), 32'(MEM_dataE_out), 32'(k == 13));
        end
        for (int k = 0; k < 4; k++) ref_mem[k] = 8'(32'hCAFE_F00D >> (8 * k));
        chk("io_ram_word", {ram[3], ram[2], ram[1], ram[0]}, 32'hCAFE_F00D);
`else
        txn(1'b0, 1'b1, 32'h0003_0000, 3'd4, 32'h1357_9BDF, 0, 0, 0);
`endif

        // random mix of loads, stores and fetches, including illegal lengths
        for (int i = 0; i < 24; i++) begin
            int typ;
            typ = int'($urandom_range(0, 2));
            txn(typ == 0, typ == 2, 32'($urandom_range(0, 4000)), 3'($urandom_range(0, 7)),
                $urandom, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL: clk_in  input  1  single clock; all state on rising edge.
REQ-002 SHALL: rst_in  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: rdy_in  input  1  global ready; low freezes the block.
REQ-004 SHALL: IC_E_in  input  1  instruction-fetch read request, level, from ICache.
REQ-005 SHALL: IC_addr_in  input  32  instruction fetch byte address.
REQ-006 SHALL: IC_instE_out  output  1  one-cycle done pulse; IC_inst_out is valid.
REQ-007 SHALL: IC_inst_out  output  32  fetched word, little-endian.
REQ-008 SHALL: IC_busy_out  output  1  high while an ICache transaction is in flight.
REQ-009 SHALL: MEM_E_in  input  1  data request, level.
REQ-010 SHALL: MEM_wr_in  input  1  1 = store, 0 = load.
REQ-011 SHALL: MEM_addr_in  input  32  data byte address.
REQ-012 SHALL: MEM_len_in  input  3  byte count; only 1, 2 and 4 are legal.
REQ-013 SHALL: MEM_data_in  input  32  store data; low bytes are used.
REQ-014 SHALL: MEM_dataE_out  output  1  one-cycle done pulse for a load or a store.
REQ-015 SHALL: MEM_data_out  output  32  load data, zero-extended.
REQ-016 SHALL: MEM_busy_out  output  1  high while a MEM transaction is in flight.
REQ-017 SHALL: ram_din_in  input  8  RAM read byte; returns the address issued one cycle earlier.
REQ-018 SHALL: ram_dout_out  output  8  RAM write byte.
REQ-019 SHALL: ram_a_out  output  32  RAM byte address.
REQ-020 SHALL: ram_wr_out  output  1  1 = write ram_dout_out to ram_a_out this cycle.

Function
REQ-021 SHALL: use FSM states IDLE, IC_READ, MEM_READ, MEM_WRITE.
REQ-022 SHALL: sample requests only in IDLE; on a simultaneous request, MEM wins over IC; an accepted transaction is never preempted.
REQ-023 SHALL: latch address, length, data and direction at acceptance; the requester may drop its request afterwards.
REQ-024 SHALL: for a request seen in IDLE cycle A, issue byte k (addr+k) in cycle A+1+k and capture it from ram_din_in in cycle A+2+k.
REQ-025 SHALL: pulse read done (IC len fixed at 4) in cycle A+2+n, n = length; for a 4-byte read this is done at A+6.
REQ-026 SHALL: drive stores with ram_wr_out=1 in cycles A+1..A+n (byte k = data[8k+7:8k]) and pulse MEM_dataE_out in A+n+1.
REQ-027 SHALL: return to IDLE on the done cycle; the earliest next acceptance is the following cycle, so a request still asserted during the done cycle is not re-accepted.
REQ-028 SHALL: hold IC_inst_out and MEM_data_out until the next completion of the same port.
REQ-029 SHALL: when rdy_in is low, hold all state and force ram_wr_out=0; capture a byte only if its address was issued with rdy_in high in the previous cycle, and reissue the address on resume.
REQ-030 SHALL: drive ram_a_out=0 and ram_wr_out=0 in IDLE.
REQ-031 SHALL: treat an illegal MEM_len_in (0, 3, 5-7) as 4.

Reset
REQ-032 SHALL: on rst_in high, enter IDLE immediately and set every output and internal register to 0.
REQ-033 SHALL: abandon any partial transaction on reset mid-operation with no done pulse; bytes already written stay in RAM.

Configuration
REQ-034 SHALL: define MEM_CTRL_IO_GUARD_EN to add an input io_buffer_full_in (1 bit); a MEM store with addr[17:16]==2'b11 is then not accepted while io_buffer_full_in is high, and lower-priority IC requests are still served.
REQ-035 SHALL: without MEM_CTRL_IO_GUARD_EN, omit the port, and I/O stores are accepted like any other store.

Structure
REQ-036 SHALL: place the state enum, length encodings (LEN_B=1, LEN_H=2, LEN_W=4) and the I/O region constant in the shared package mem_ctrl_pkg.
REQ-037 SHALL: implement arbitration (priority, IDLE-only grant, I/O guard) in one sub-module, mem_ctrl_arb; sequencing and byte assembly stay in mem_ctrl.

Verification
REQ-038 SHALL cover: IC read of 0x00000104 with RAM bytes 0x13,0x05,0x00,0x00 -> IC_instE_out pulses at A+6 with IC_inst_out=0x00000513; IC_busy_out is high A+1..A+6.
REQ-039 SHALL cover: IC and MEM load (len 2, addr 0x200, bytes 0xCD,0xAB) both raised in the same IDLE cycle -> MEM served first, MEM_data_out=0x0000ABCD at A+4; IC accepted at A+5.
REQ-040 SHALL cover: MEM store len 4, addr 0x300, data 0xDEADBEEF -> ram_wr_out high 4 cycles with bytes EF,BE,AD,DE at 0x300..0x303; done at A+5.
REQ-041 SHALL cover: rdy_in low for 3 cycles mid-read -> correct word; done delayed by exactly 3 cycles; no write strobe while rdy_in is low.
REQ-042 SHALL cover: rst_in raised asynchronously during byte 2 of a store -> outputs zero at once, no done pulse, next request served normally.
REQ-043 SHALL cover: with MEM_CTRL_IO_GUARD_EN defined, a store to 0x30000 while io_buffer_full_in=1 -> not accepted and a pending IC read completes; after io_buffer_full_in falls, the store is accepted.
